// File: rtl/ap_addsub_arb_pkg.sv
// rtl/ap_addsub_arb_pkg.sv - shared constants and helpers for the add/sub arbiter
package ap_addsub_arb_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bit w is set when an arithmetic core exists at width w.
  localparam logic [127:0] WIDTH_LEGAL_MASK =
    (128'd1 << 8) | (128'd1 << 16) | (128'd1 << 32) | (128'd1 << 64);

  function automatic bit width_legal(input int w);
    return (w >= 0) && (w < 128) && WIDTH_LEGAL_MASK[w];
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int p = 1; p < n; p = p * 2) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/ap_addI.sv
// rtl/ap_addI.sv - combinational integer adder core, carry discarded
module ap_addI #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a + b;

endmodule

// File: rtl/ap_subI.sv
// rtl/ap_subI.sv - combinational integer subtractor core, borrow discarded
module ap_subI #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a - b;

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin priority scan starting at ptr
module rr_arbiter
  import ap_addsub_arb_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int IDW   = clog2(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [PORTS-1:0] grant,
  output logic [IDW-1:0]   idx,
  output logic             any
);

  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    // ptr is always kept below PORTS, so one subtraction wraps the scan.
    for (int k = 0; k < PORTS; k++) begin
      j = int'(ptr) + k;
      if (j >= PORTS) j = j - PORTS;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/ap_addsub_arb.sv
// rtl/ap_addsub_arb.sv - shares one add/sub datapath among PORTS requesters
module ap_addsub_arb
  import ap_addsub_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PORTS = 4,
  parameter int IDW   = clog2(PORTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PORTS-1:0]       req_valid,
  output logic [PORTS-1:0]       req_ready,
  input  logic [PORTS-1:0]       req_sub,
  input  logic [PORTS*WIDTH-1:0] req_a,
  input  logic [PORTS*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_data
);

  localparam bit WIDTH_OK = width_legal(WIDTH);

  if (!WIDTH_OK) begin : g_width_check
    $error("ap_addsub_arb: WIDTH must be 8, 16, 32 or 64");
  end

  logic [IDW-1:0]   ptr;
  logic [PORTS-1:0] grant;
  logic [IDW-1:0]   win_idx;
  logic             win_any;
  logic             can_accept;
  logic             take;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic             win_sub;
  logic [WIDTH-1:0] add_y;
  logic [WIDTH-1:0] sub_y;
  logic [WIDTH-1:0] result;
  logic [IDW-1:0]   ptr_next;

  rr_arbiter #(
    .PORTS (PORTS),
    .IDW   (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign can_accept = !rsp_valid || rsp_ready;
  // Gate on rst so nothing appears accepted while reset is held.
  assign req_ready  = (rst && can_accept) ? grant : '0;
  assign take       = win_any && can_accept;

  assign win_a   = req_a[win_idx*WIDTH +: WIDTH];
  assign win_b   = req_b[win_idx*WIDTH +: WIDTH];
  assign win_sub = req_sub[win_idx];

  ap_addI #(.WIDTH(WIDTH)) u_add (.a(win_a), .b(win_b), .y(add_y));
  ap_subI #(.WIDTH(WIDTH)) u_sub (.a(win_a), .b(win_b), .y(sub_y));

  assign result   = (win_sub == OP_SUB) ? sub_y : add_y;
  assign ptr_next = (win_idx == IDW'(PORTS - 1)) ? '0 : win_idx + IDW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      ptr       <= '0;
    end else if (take) begin
      rsp_valid <= 1'b1;
      rsp_id    <= win_idx;
      rsp_data  <= result;
      ptr       <= ptr_next;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ap_addsub_arb.sv
// tb/tb_ap_addsub_arb.sv - directed bench for the add/sub arbiter
module tb_ap_addsub_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_ready, req_sub;
  logic [127:0] req_a, req_b;
  logic         rsp_valid, rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;

  logic [1:0]   v8, rdy8, sub8;
  logic [15:0]  a8, b8;
  logic         rv8, rr8;
  logic [0:0]   id8;
  logic [7:0]   data8;

  int checks = 0;
  int errors = 0;

  // Per-port results for the operands loaded by load_ports.
  logic [31:0] exp_res [4];
  int          exp_order [6];

  always #5 clk = ~clk;

  ap_addsub_arb #(.WIDTH(32), .PORTS(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_sub(req_sub), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  ap_addsub_arb #(.WIDTH(8), .PORTS(2)) dut8 (
    .clk(clk), .rst(rst), .req_valid(v8), .req_ready(rdy8),
    .req_sub(sub8), .req_a(a8), .req_b(b8), .rsp_valid(rv8),
    .rsp_ready(rr8), .rsp_id(id8), .rsp_data(data8)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ports();
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = 32'(10 * (i + 1));
      req_b[i*32 +: 32] = 32'(i);
      req_sub[i]        = i[0];
    end
    exp_res[0] = 32'd10;
    exp_res[1] = 32'd19;
    exp_res[2] = 32'd32;
    exp_res[3] = 32'd37;
  endtask

  task automatic test_reset();
    req_valid = 4'hF;
    #2;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL reset_rsp_data: got %0h expected 0", rsp_data); end
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready: got %0b expected 0000", req_ready); end
    checks++; if (rv8 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid8: got %0b expected 0", rv8); end
    req_valid = 4'h0;
    #10;
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_single_op();
    req_a[2*32 +: 32] = 32'h0000_0005;
    req_b[2*32 +: 32] = 32'h0000_0003;
    req_sub[2] = 1'b0;
    req_valid  = 4'b0100;
    rsp_ready  = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %0b expected 0100", req_ready); end
    cyc();
    req_valid = 4'h0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b expected 1", rsp_valid); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d expected 2", rsp_id); end
    checks++; if (rsp_data !== 32'h0000_0008) begin errors++; $display("FAIL single_data: got %0h expected 8", rsp_data); end
    cyc();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %0b expected 0", rsp_valid); end
  endtask

  task automatic test_wrap();
    rr8 = 1'b1;
    v8 = 2'b01; a8[7:0] = 8'hFF; b8[7:0] = 8'h01; sub8[0] = 1'b0;
    #1;
    cyc();
    checks++; if (data8 !== 8'h00 || id8 !== 1'b0) begin errors++; $display("FAIL wrap_add: got id %0d data %0h expected id 0 data 00", id8, data8); end
    v8 = 2'b10; a8[15:8] = 8'h00; b8[15:8] = 8'h01; sub8[1] = 1'b1;
    #1;
    cyc();
    checks++; if (data8 !== 8'hFF || id8 !== 1'b1) begin errors++; $display("FAIL wrap_sub: got id %0d data %0h expected id 1 data ff", id8, data8); end
    v8 = 2'b00;
    req_a[32 +: 32] = 32'hFFFF_FFFF; req_b[32 +: 32] = 32'h0000_0001; req_sub[1] = 1'b0;
    req_valid = 4'b0010;
    #1;
    cyc();
    req_valid = 4'h0;
    checks++; if (rsp_data !== 32'h0 || rsp_id !== 2'd1) begin errors++; $display("FAIL wrap_add32: got id %0d data %0h expected id 1 data 0", rsp_id, rsp_data); end
    cyc();
  endtask

  task automatic test_pointer_hold();
    load_ports();
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL hold_ready3: got %0b expected 1000", req_ready); end
    cyc();
    checks++; if (rsp_id !== 2'd3 || rsp_data !== exp_res[3]) begin errors++; $display("FAIL hold_rsp3: got id %0d data %0h expected id 3 data %0h", rsp_id, rsp_data, exp_res[3]); end
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL hold_ready0: got %0b expected 0001", req_ready); end
    cyc();
    req_valid = 4'b1000;
    checks++; if (rsp_id !== 2'd0 || rsp_data !== exp_res[0]) begin errors++; $display("FAIL hold_rsp0: got id %0d data %0h expected id 0 data %0h", rsp_id, rsp_data, exp_res[0]); end
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL hold_ready3b: got %0b expected 1000", req_ready); end
    cyc();
    req_valid = 4'h0;
    checks++; if (rsp_id !== 2'd3) begin errors++; $display("FAIL hold_rsp3b: got id %0d expected 3", rsp_id); end
    cyc();
  endtask

  task automatic test_round_robin();
    exp_order = '{0, 1, 2, 3, 0, 1};
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (req_ready !== 4'(1 << exp_order[k])) begin errors++; $display("FAIL rr_ready[%0d]: got %0b expected port %0d", k, req_ready, exp_order[k]); end
      cyc();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_order[k]) || rsp_data !== exp_res[exp_order[k]]) begin
        errors++; $display("FAIL rr_rsp[%0d]: got v %0b id %0d data %0h expected v 1 id %0d data %0h", k, rsp_valid, rsp_id, rsp_data, exp_order[k], exp_res[exp_order[k]]);
      end
    end
    req_valid = 4'h0;
    cyc();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_drain: got %0b expected 0", rsp_valid); end
  endtask

  task automatic test_back_pressure();
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_first_ready: got %0b expected 0100", req_ready); end
    cyc();
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (req_ready !== 4'h0 || rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== exp_res[2]) begin
        errors++; $display("FAIL bp_hold[%0d]: got ready %0b v %0b id %0d data %0h expected ready 0000 v 1 id 2 data %0h", k, req_ready, rsp_valid, rsp_id, rsp_data, exp_res[2]);
      end
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_release_ready: got %0b expected 1000", req_ready); end
    cyc();
    req_valid = 4'h0;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== exp_res[3]) begin
      errors++; $display("FAIL bp_no_bubble: got v %0b id %0d data %0h expected v 1 id 3 data %0h", rsp_valid, rsp_id, rsp_data, exp_res[3]);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    cyc();
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("FAIL rmid_pre: got v %0b id %0d expected v 1 id 0", rsp_valid, rsp_id); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'd0) begin errors++; $display("FAIL rmid_async: got v %0b data %0h expected v 0 data 0", rsp_valid, rsp_data); end
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL rmid_ready: got %0b expected 0000", req_ready); end
    rsp_ready = 1'b1;
    cyc();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'h0) begin errors++; $display("FAIL rmid_held: got v %0b ready %0b expected v 0 ready 0000", rsp_valid, req_ready); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_first_ready: got %0b expected 0001", req_ready); end
    cyc();
    req_valid = 4'h0;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== exp_res[0]) begin
      errors++; $display("FAIL rmid_first_rsp: got v %0b id %0d data %0h expected v 1 id 0 data %0h", rsp_valid, rsp_id, rsp_data, exp_res[0]);
    end
    cyc();
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0; req_sub = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    v8 = '0; sub8 = '0; a8 = '0; b8 = '0; rr8 = 1'b0;
    test_reset();
    test_single_op();
    test_wrap();
    test_pointer_hold();
    test_round_robin();
    test_back_pressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
